multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Control unit for the multicycle RV32I core variant, which shares one memory port and one ALU.
- Moore FSM sequences fetch, decode, execute, memory and writeback per instruction.
- Generates datapath select and strobe signals.
- Honours a memory ready handshake.
- Flags illegal or unsupported opcodes.
- Pulses a retire strobe for performance counters.
- Parameters add optional JALR, LUI/AUIPC and wait-state support beyond the single-cycle decoder.

Parameters:
SUPPORT_JALR, 1, when 1 JALR (1100111) is decoded; when 0 it is illegal
SUPPORT_UTYPE, 1, when 1 LUI (0110111) and AUIPC (0010111) are decoded; when 0 they are illegal
MEM_HANDSHAKE, 1, when 1 memory states wait for mem_ready; when 0 mem_ready is treated as constant 1

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
op  in  7  instr[6:0] from IR
funct3  in  3  instr[14:12]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current request this cycle
adr_src  out  1  0: PC, 1: ALUOut
mem_req  out  1  memory access request
mem_write  out  1  store strobe
ir_write  out  1  IR/OldPC load
pc_write  out  1  PC load
pc_src  out  1  PC input select; 0: Result, 1: ALUResult
reg_write  out  1  register file write
result_src  out  2  00: ALUOut, 01: Data, 10: ALUResult, 11: PC
alu_src_a  out  2  00: PC, 01: OldPC, 10: rs1, 11: zero
alu_src_b  out  2  00: rs2, 01: imm, 10: constant 4
alu_op  out  2  00: add, 01: subtract (branch), 10: funct-decoded
imm_src  out  3  combinational from op; I=000, S=001, B=010, J=011, U=100, other=000
illegal_instr  out  1  1-cycle pulse
instr_retire  out  1  1-cycle pulse
state_dbg  out  4  current state encoding

Behaviour:
- State encoding (4-bit register): FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, JALR=11, LUI=12, AUIPC=13. Codes 14/15 go to FETCH.
- Reset:
  - State goes to FETCH asynchronously.
  - While reset=1, all strobes (mem_req, mem_write, ir_write, pc_write, reg_write, illegal_instr, instr_retire) are 0 and selects are 0.
  - A reset mid-store drops mem_write immediately.
- Unlisted selects in each state are 0.
- "ready" below means mem_ready, or 1 when MEM_HANDSHAKE=0.
- FETCH:
  - adr_src=0, mem_req=1, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - ir_write and pc_write are asserted only when ready.
  - Goes to DECODE when ready; otherwise holds in FETCH.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target into ALUOut). Next state by op:
  - lw → MEMADR; sw → MEMADR
  - R (0110011) → EXECR; I (0010011) → EXECI
  - 1100011 with funct3 ∈ {000, 001} → BRANCH
  - jal → JAL
  - jalr → JALR (if enabled)
  - lui → LUI, auipc → AUIPC (if enabled)
  - Anything else: illegal_instr=1 and instr_retire=1 this cycle, next state FETCH.
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Next MEMREAD if op=lw, else MEMWRITE.
- MEMREAD: adr_src=1, mem_req=1. Holds until ready, then MEMWB.
- MEMWB: result_src=01, reg_write=1, instr_retire=1. Next FETCH.
- MEMWRITE:
  - adr_src=1, mem_req=1, mem_write=1, held until ready.
  - instr_retire=1 in the ready cycle, then FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10. Next ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=10. Next ALUWB.
- ALUWB: result_src=00, reg_write=1, instr_retire=1. Next FETCH.
- BRANCH:
  - alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00.
  - pc_write = zero XOR funct3[0] (BEQ taken on zero=1, BNE on zero=0).
  - instr_retire=1. Next FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1. Next ALUWB (writes OldPC+4).
- JALR:
  - alu_src_a=10, alu_src_b=01, alu_op=00, pc_src=1, pc_write=1.
  - result_src=11 (PC register holds OldPC+4), reg_write=1.
  - instr_retire=1. Next FETCH.
- LUI: alu_src_a=11, alu_src_b=01, alu_op=00. Next ALUWB.
- AUIPC: alu_src_a=01, alu_src_b=01, alu_op=00. Next ALUWB.
- Cycle counts with no wait states:
  - lw 5, sw 4, R/I 4, branch 3, jal 4, jalr 3, lui/auipc 4, illegal 2.
  - Each wait cycle adds 1.
- pc_write and ir_write are never asserted outside FETCH, except pc_write in BRANCH, JAL and JALR.

Test Plan:
- Reset with op=0000011, mem_ready=1 → while reset=1, state_dbg=0 and all strobes 0. After release: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, then FETCH; reg_write and instr_retire high only in the 5th cycle.
- sw with mem_ready low for 3 cycles in MEMWRITE → mem_write high for 4 cycles, instr_retire pulses once on the ready cycle. With MEM_HANDSHAKE=0, mem_write lasts 1 cycle.
- Branch:
  - beq (funct3=000) with zero=1 → pc_write=1 in BRANCH; with zero=0 → pc_write=0.
  - bne (001) → pc_write=1 when zero=0.
  - funct3=100 → illegal_instr pulse in DECODE.
- jalr with SUPPORT_JALR=1 → 3 cycles; JALR state drives pc_src=1, result_src=11, reg_write=1, pc_write=1. With SUPPORT_JALR=0 → illegal_instr=1, FETCH next.
- lui with SUPPORT_UTYPE=1 → imm_src=100, LUI state alu_src_a=11, then ALUWB with reg_write=1. Opcode 1111111 → illegal_instr pulse, no reg_write or mem_write.
- Assert reset during MEMWRITE with mem_ready=0 → mem_write drops in the same cycle, state_dbg=0. After release, fetch restarts with ir_write only on mem_ready.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Control unit for the multicycle RV32I core. It shares one memory port and
// one ALU between all instruction phases.
// A Moore FSM steps each instruction through fetch, decode, execute, memory
// and writeback. The outputs are decoded from the state register. They also
// depend on the memory ready handshake and, in DECODE, on the opcode.
// All strobes and selects are forced low while reset is high, so a reset that
// arrives during a store removes mem_write in the same cycle.
module multicycle_ctrl #(
    parameter bit SUPPORT_JALR  = 1'b1,
    parameter bit SUPPORT_UTYPE = 1'b1,
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       adr_src,
    output logic       mem_req,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [2:0] imm_src,
    output logic       illegal_instr,
    output logic       instr_retire,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12,
        S_AUIPC    = 4'd13
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    state_t     state_r;
    state_t     state_next_s;
    logic       ready_s;

    logic       adr_src_s;
    logic       mem_req_s;
    logic       mem_write_s;
    logic       ir_write_s;
    logic       pc_write_s;
    logic       pc_src_s;
    logic       reg_write_s;
    logic [1:0] result_src_s;
    logic [1:0] alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] alu_op_s;
    logic [2:0] imm_src_s;
    logic       illegal_s;
    logic       retire_s;

    // Returns the state that follows DECODE, or FETCH for an opcode this build does not execute.
    function automatic state_t decode_next(input logic [6:0] op_v, input logic [2:0] f3_v);
        state_t ns;
        ns = S_FETCH;
        case (op_v)
            OP_LW, OP_SW: ns = S_MEMADR;
            OP_R:         ns = S_EXECR;
            OP_I:         ns = S_EXECI;
            OP_BR: begin
                if (f3_v == 3'b000 || f3_v == 3'b001) ns = S_BRANCH;
                else                                  ns = S_FETCH;
            end
            OP_JAL:       ns = S_JAL;
            OP_JALR: begin
                if (SUPPORT_JALR) ns = S_JALR;
                else              ns = S_FETCH;
            end
            OP_LUI: begin
                if (SUPPORT_UTYPE) ns = S_LUI;
                else               ns = S_FETCH;
            end
            OP_AUIPC: begin
                if (SUPPORT_UTYPE) ns = S_AUIPC;
                else               ns = S_FETCH;
            end
            default:      ns = S_FETCH;
        endcase
        return ns;
    endfunction

    assign ready_s = MEM_HANDSHAKE ? mem_ready : 1'b1;

    // State register; reset returns to FETCH asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_r <= S_FETCH;
        else       state_r <= state_next_s;
    end

    // Selects the immediate format from the opcode alone, without regard to the current state.
    always_comb begin
        imm_src_s = 3'b000;
        case (op)
            OP_SW:            imm_src_s = 3'b001;
            OP_BR:            imm_src_s = 3'b010;
            OP_JAL:           imm_src_s = 3'b011;
            OP_LUI, OP_AUIPC: imm_src_s = 3'b100;
            default:          imm_src_s = 3'b000;
        endcase
    end

    // Next-state logic and per-state datapath controls; anything not set here stays 0.
    always_comb begin
        state_next_s = S_FETCH;
        adr_src_s    = 1'b0;
        mem_req_s    = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        pc_write_s   = 1'b0;
        pc_src_s     = 1'b0;
        reg_write_s  = 1'b0;
        result_src_s = 2'b00;
        alu_src_a_s  = 2'b00;
        alu_src_b_s  = 2'b00;
        alu_op_s     = 2'b00;
        illegal_s    = 1'b0;
        retire_s     = 1'b0;
        case (state_r)
            S_FETCH: begin
                mem_req_s    = 1'b1;
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b10;
                ir_write_s   = ready_s;
                pc_write_s   = ready_s;
                if (ready_s) state_next_s = S_DECODE;
                else         state_next_s = S_FETCH;
            end
            S_DECODE: begin
                // Compute the branch target into ALUOut while the opcode is decoded.
                alu_src_a_s  = 2'b01;
                alu_src_b_s  = 2'b01;
                state_next_s = decode_next(op, funct3);
                if (decode_next(op, funct3) == S_FETCH) begin
                    illegal_s = 1'b1;
                    retire_s  = 1'b1;
                end else begin
                    illegal_s = 1'b0;
                    retire_s  = 1'b0;
                end
            end
            S_MEMADR: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                if (op == OP_LW) state_next_s = S_MEMREAD;
                else             state_next_s = S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src_s = 1'b1;
                mem_req_s = 1'b1;
                if (ready_s) state_next_s = S_MEMWB;
                else         state_next_s = S_MEMREAD;
            end
            S_MEMWB: begin
                result_src_s = 2'b01;
                reg_write_s  = 1'b1;
                retire_s     = 1'b1;
                state_next_s = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src_s   = 1'b1;
                mem_req_s   = 1'b1;
                mem_write_s = 1'b1;
                retire_s    = ready_s;
                if (ready_s) state_next_s = S_FETCH;
                else         state_next_s = S_MEMWRITE;
            end
            S_EXECR: begin
                alu_src_a_s  = 2'b10;
                alu_op_s     = 2'b10;
                state_next_s = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a_s  = 2'b10;
                alu_src_b_s  = 2'b01;
                alu_op_s     = 2'b10;
                state_next_s = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_s  = 1'b1;
                retire_s     = 1'b1;
                state_next_s = S_FETCH;
            end
            S_BRANCH: begin
                // BEQ is taken when zero is set; BNE (funct3[0]=1) is taken when it is clear.
                alu_src_a_s  = 2'b10;
                alu_op_s     = 2'b01;
                pc_write_s   = zero ^ funct3[0];
                retire_s     = 1'b1;
                state_next_s = S_FETCH;
            end
            S_JAL: begin
                // The target is already in ALUOut; the ALU now forms OldPC+4 for the link write.
                alu_src_a_s  = 2'b01;
                alu_src_b_s  = 2'b10;
                pc_write_s   = 1'b1;
                state_next_s = S_ALUWB;
            end
            S_JALR: begin
                // The PC register still holds OldPC+4, so it supplies the link value directly.
                alu_src_a_s  = 2'b10;
                alu_src_b_s  = 2'b01;
                pc_src_s     = 1'b1;
                pc_write_s   = 1'b1;
                result_src_s = 2'b11;
                reg_write_s  = 1'b1;
                retire_s     = 1'b1;
                state_next_s = S_FETCH;
            end
            S_LUI: begin
                alu_src_a_s  = 2'b11;
                alu_src_b_s  = 2'b01;
                state_next_s = S_ALUWB;
            end
            S_AUIPC: begin
                alu_src_a_s  = 2'b01;
                alu_src_b_s  = 2'b01;
                state_next_s = S_ALUWB;
            end
            default: begin
                state_next_s = S_FETCH;
            end
        endcase
    end

    // Forces every strobe and select low while reset is asserted.
    always_comb begin
        if (reset) begin
            adr_src       = 1'b0;
            mem_req       = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            pc_src        = 1'b0;
            reg_write     = 1'b0;
            result_src    = 2'b00;
            alu_src_a     = 2'b00;
            alu_src_b     = 2'b00;
            alu_op        = 2'b00;
            imm_src       = 3'b000;
            illegal_instr = 1'b0;
            instr_retire  = 1'b0;
        end else begin
            adr_src       = adr_src_s;
            mem_req       = mem_req_s;
            mem_write     = mem_write_s;
            ir_write      = ir_write_s;
            pc_write      = pc_write_s;
            pc_src        = pc_src_s;
            reg_write     = reg_write_s;
            result_src    = result_src_s;
            alu_src_a     = alu_src_a_s;
            alu_src_b     = alu_src_b_s;
            alu_op        = alu_op_s;
            imm_src       = imm_src_s;
            illegal_instr = illegal_s;
            instr_retire  = retire_s;
        end
    end

    assign state_dbg = state_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl. It drives two instances from the same
// input signals and holds one of them in reset at any time: u_a uses the
// default build and u_b is built with JALR, U-type and the handshake disabled.
// The driver computes, for each instruction, a summary of what the instruction
// window should contain and pushes it into a queue. The monitor counts what
// the active DUT does and compares at each retire pulse.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       zero;
    logic       mem_ready;
    bit         sel;
    bit         mon_en;

    int tests = 0;
    int fails = 0;

    logic a_adr, a_mreq, a_mw, a_ir, a_pcw, a_psrc, a_rw, a_ill, a_ret;
    logic [1:0] a_rs, a_sa, a_sb, a_aop;
    logic [2:0] a_imm;
    logic [3:0] a_st;
    logic b_adr, b_mreq, b_mw, b_ir, b_pcw, b_psrc, b_rw, b_ill, b_ret;
    logic [1:0] b_rs, b_sa, b_sb, b_aop;
    logic [2:0] b_imm;
    logic [3:0] b_st;

    always #5 clk = ~clk;

    multicycle_ctrl u_a (
        .clk(clk), .reset(rst_a), .op(op), .funct3(funct3), .zero(zero), .mem_ready(mem_ready),
        .adr_src(a_adr), .mem_req(a_mreq), .mem_write(a_mw), .ir_write(a_ir), .pc_write(a_pcw),
        .pc_src(a_psrc), .reg_write(a_rw), .result_src(a_rs), .alu_src_a(a_sa), .alu_src_b(a_sb),
        .alu_op(a_aop), .imm_src(a_imm), .illegal_instr(a_ill), .instr_retire(a_ret), .state_dbg(a_st)
    );

    multicycle_ctrl #(.SUPPORT_JALR(1'b0), .SUPPORT_UTYPE(1'b0), .MEM_HANDSHAKE(1'b0)) u_b (
        .clk(clk), .reset(rst_b), .op(op), .funct3(funct3), .zero(zero), .mem_ready(mem_ready),
        .adr_src(b_adr), .mem_req(b_mreq), .mem_write(b_mw), .ir_write(b_ir), .pc_write(b_pcw),
        .pc_src(b_psrc), .reg_write(b_rw), .result_src(b_rs), .alu_src_a(b_sa), .alu_src_b(b_sb),
        .alu_op(b_aop), .imm_src(b_imm), .illegal_instr(b_ill), .instr_retire(b_ret), .state_dbg(b_st)
    );

    // Outputs of whichever DUT is active.
    logic m_adr, m_mreq, m_mw, m_ir, m_pcw, m_psrc, m_rw, m_ill, m_ret;
    logic [1:0] m_rs, m_sa, m_sb, m_aop;
    logic [2:0] m_imm;
    logic [3:0] m_st;
    assign m_adr  = sel ? b_adr  : a_adr;
    assign m_mreq = sel ? b_mreq : a_mreq;
    assign m_mw   = sel ? b_mw   : a_mw;
    assign m_ir   = sel ? b_ir   : a_ir;
    assign m_pcw  = sel ? b_pcw  : a_pcw;
    assign m_psrc = sel ? b_psrc : a_psrc;
    assign m_rw   = sel ? b_rw   : a_rw;
    assign m_ill  = sel ? b_ill  : a_ill;
    assign m_ret  = sel ? b_ret  : a_ret;
    assign m_rs   = sel ? b_rs   : a_rs;
    assign m_sa   = sel ? b_sa   : a_sa;
    assign m_sb   = sel ? b_sb   : a_sb;
    assign m_aop  = sel ? b_aop  : a_aop;
    assign m_imm  = sel ? b_imm  : a_imm;
    assign m_st   = sel ? b_st   : a_st;

    // Expected summary of one instruction window (FETCH through the retire cycle).
    typedef struct {
        int cyc; int ir; int pc; int rw; int mw; int mreq; int psrc; int ill;
        int imm; int rs; int s3; int a3; int o3; int mem_at;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: instruction class -> cycle count, strobe counts and key selects.
    function automatic exp_t model(input logic [6:0] o, input logic [2:0] f3, input logic z,
                                   input int fw, input int mw, input bit altm);
        exp_t e;
        bit jen, uen, hs, illegal;
        int W, M;
        jen = !altm; uen = !altm; hs = !altm;
        W = hs ? fw : 0;
        M = hs ? mw : 0;
        illegal = 1'b0;
        e.cyc = 4 + W; e.ir = 1; e.pc = 1; e.rw = 0; e.mw = 0; e.mreq = W + 1; e.psrc = 0;
        e.ill = 0; e.imm = 0; e.rs = 0; e.s3 = -1; e.a3 = -1; e.o3 = -1; e.mem_at = -1;
        case (o)
            7'b0100011: e.imm = 1;
            7'b1100011: e.imm = 2;
            7'b1101111: e.imm = 3;
            7'b0110111, 7'b0010111: e.imm = 4;
            default: e.imm = 0;
        endcase
        case (o)
            7'b0000011: begin
                e.cyc = 5 + W + M; e.rw = 1; e.mreq += M + 1; e.rs = 1;
                e.s3 = 2; e.a3 = 2; e.o3 = 0; e.mem_at = W + 3;
            end
            7'b0100011: begin
                e.cyc = 4 + W + M; e.mw = M + 1; e.mreq += M + 1;
                e.s3 = 2; e.a3 = 2; e.o3 = 0; e.mem_at = W + 3;
            end
            7'b0110011: begin e.rw = 1; e.s3 = 6; e.a3 = 2; e.o3 = 2; end
            7'b0010011: begin e.rw = 1; e.s3 = 7; e.a3 = 2; e.o3 = 2; end
            7'b1100011: begin
                if (f3 == 3'd0 || f3 == 3'd1) begin
                    e.cyc = 3 + W; e.pc = 1 + ((z != f3[0]) ? 1 : 0);
                    e.s3 = 9; e.a3 = 2; e.o3 = 1;
                end else illegal = 1'b1;
            end
            7'b1101111: begin e.pc = 2; e.rw = 1; e.s3 = 10; e.a3 = 1; e.o3 = 0; end
            7'b1100111: begin
                if (jen) begin
                    e.cyc = 3 + W; e.pc = 2; e.rw = 1; e.psrc = 1; e.rs = 3;
                    e.s3 = 11; e.a3 = 2; e.o3 = 0;
                end else illegal = 1'b1;
            end
            7'b0110111: begin
                if (uen) begin e.rw = 1; e.s3 = 12; e.a3 = 3; e.o3 = 0; end
                else illegal = 1'b1;
            end
            7'b0010111: begin
                if (uen) begin e.rw = 1; e.s3 = 13; e.a3 = 1; e.o3 = 0; end
                else illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            e.cyc = 2 + W; e.ill = 1;
        end
        return e;
    endfunction

    // Issue one instruction from FETCH (called at posedge+1) and run it to completion.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic z,
                             input int fw, input int mw);
        exp_t e;
        e = model(o, f3, z, fw, mw, sel);
        q.push_back(e);
        op = o; funct3 = f3; zero = z;
        for (int c = 0; c < e.cyc; c++) begin
            if (!sel) begin
                if (c <= fw) mem_ready = (c == fw);
                else if (e.mem_at >= 0 && c >= e.mem_at && c <= e.mem_at + mw)
                    mem_ready = (c == e.mem_at + mw);
                else mem_ready = 1'($urandom_range(0, 1));
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic run_random(input int n);
        logic [6:0] o;
        logic [2:0] f3;
        for (int i = 0; i < n; i++) begin
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 11))
                0: o = 7'b0000011;
                1: o = 7'b0100011;
                2, 11: o = 7'b0110011;
                3: o = 7'b0010011;
                4: begin o = 7'b1100011; f3 = 3'($urandom_range(0, 3)); end
                5: o = 7'b1101111;
                6: o = 7'b1100111;
                7: o = 7'b0110111;
                8: o = 7'b0010111;
                9: o = 7'b1111111;
                default: o = 7'($urandom_range(0, 127));
            endcase
            run_instr(o, f3, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3));
        end
    endtask

    // Monitor accumulators for the current instruction window.
    int a_cyc, a_irc, a_pc, a_rwc, a_mwc, a_mreqc, a_psc, a_illc, a_imm_v, a_s3, a_a3, a_o3, a_ir_at;
    exp_t ex;

    task automatic clear_acc();
        a_cyc = 0; a_irc = 0; a_pc = 0; a_rwc = 0; a_mwc = 0; a_mreqc = 0; a_psc = 0; a_illc = 0;
        a_imm_v = -1; a_s3 = -1; a_a3 = -1; a_o3 = -1; a_ir_at = -10;
    endtask

    // Monitor: count the active DUT's activity and compare against the queue at each retire.
    always @(negedge clk) begin
        if (!mon_en) begin
            clear_acc();
        end else begin
            if (m_ir) begin a_irc++; a_ir_at = a_cyc; end
            if (m_pcw) a_pc++;
            if (m_rw) a_rwc++;
            if (m_mw) a_mwc++;
            if (m_mreq) a_mreqc++;
            if (m_psrc) a_psc++;
            if (m_ill) a_illc++;
            if (a_cyc == a_ir_at + 1) a_imm_v = int'(m_imm);
            if (a_cyc == a_ir_at + 2) begin
                a_s3 = int'(m_st); a_a3 = int'(m_sa); a_o3 = int'(m_aop);
            end
            a_cyc++;
            if (m_ret) begin
                if (q.size() == 0) begin
                    chk("unexpected_retire", 1, 0);
                end else begin
                    ex = q.pop_front();
                    chk("cycles", a_cyc, ex.cyc);
                    chk("ir_write_cnt", a_irc, ex.ir);
                    chk("pc_write_cnt", a_pc, ex.pc);
                    chk("reg_write_cnt", a_rwc, ex.rw);
                    chk("mem_write_cnt", a_mwc, ex.mw);
                    chk("mem_req_cnt", a_mreqc, ex.mreq);
                    chk("pc_src_cnt", a_psc, ex.psrc);
                    chk("illegal_cnt", a_illc, ex.ill);
                    chk("imm_src", a_imm_v, ex.imm);
                    chk("retire_result_src", int'(m_rs), ex.rs);
                    chk("exec_state", a_s3, ex.s3);
                    chk("exec_alu_src_a", a_a3, ex.a3);
                    chk("exec_alu_op", a_o3, ex.o3);
                end
                clear_acc();
            end else if (a_cyc > 40) begin
                chk("retire_timeout", a_cyc, 0);
                clear_acc();
            end
        end
    end

    int strobes;

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; sel = 1'b0; mon_en = 1'b0;
        op = 7'b0000011; funct3 = 3'b010; zero = 1'b0; mem_ready = 1'b1;
        clear_acc();

        // Reset state of the default build.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_state", int'(m_st), 0);
        strobes = int'({m_mreq, m_mw, m_ir, m_pcw, m_rw, m_ill, m_ret});
        chk("rst_strobes", strobes, 0);
        chk("rst_selects", int'({m_adr, m_psrc, m_rs, m_sa, m_sb, m_aop}), 0);
        @(posedge clk); #1 rst_a = 1'b0;

        // First lw after release: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, then FETCH.
        mon_en = 1'b1;
        q.push_back(model(7'b0000011, 3'b010, 1'b0, 0, 0, 1'b0));
        for (int c = 0; c < 5; c++) begin
            chk("lw_path", int'(m_st), c);
            mem_ready = 1'b1;
            @(posedge clk); #1;
        end
        chk("lw_path_end", int'(m_st), 0);

        // Branch, jump and opcode corner cases.
        run_instr(7'b1100011, 3'b000, 1'b1, 0, 0);
        run_instr(7'b1100011, 3'b000, 1'b0, 1, 0);
        run_instr(7'b1100011, 3'b001, 1'b0, 0, 0);
        run_instr(7'b1100011, 3'b001, 1'b1, 0, 0);
        run_instr(7'b1100011, 3'b100, 1'b1, 0, 0);
        run_instr(7'b1100111, 3'b000, 1'b0, 0, 0);
        run_instr(7'b0110111, 3'b000, 1'b0, 0, 0);
        run_instr(7'b1111111, 3'b000, 1'b0, 0, 0);
        run_instr(7'b0100011, 3'b010, 1'b0, 0, 3);
        run_instr(7'b0000011, 3'b010, 1'b0, 2, 2);
        run_random(150);

        // Reset during a stalled store.
        mon_en = 1'b0;
        op = 7'b0100011; mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("store_wait_state", int'(m_st), 5);
        chk("store_wait_mem_write", int'(m_mw), 1);
        #2 rst_a = 1'b1;
        #1;
        chk("rst_mid_store_mem_write", int'(m_mw), 0);
        chk("rst_mid_store_state", int'(m_st), 0);
        chk("rst_mid_store_mem_req", int'(m_mreq), 0);
        @(negedge clk) rst_a = 1'b0;
        @(posedge clk); #1;
        chk("refetch_wait_ir", int'(m_ir), 0);
        chk("refetch_wait_state", int'(m_st), 0);
        @(posedge clk); #1;
        chk("refetch_wait_ir2", int'(m_ir), 0);
        mem_ready = 1'b1;
        #1;
        chk("refetch_ready_ir", int'(m_ir), 1);
        chk("refetch_ready_pc", int'(m_pcw), 1);
        rst_a = 1'b1;
        @(posedge clk); #1 rst_a = 1'b0;
        mon_en = 1'b1;
        run_random(20);

        // Switch to the reduced build.
        mon_en = 1'b0;
        rst_a = 1'b1;
        sel = 1'b1;
        @(negedge clk);
        chk("alt_rst_state", int'(m_st), 0);
        chk("alt_rst_strobes", int'({m_mreq, m_mw, m_ir, m_pcw, m_rw, m_ill, m_ret}), 0);
        @(posedge clk); #1 rst_b = 1'b0;
        mon_en = 1'b1;
        run_instr(7'b0100011, 3'b010, 1'b0, 2, 3);
        run_instr(7'b1100111, 3'b000, 1'b0, 0, 0);
        run_instr(7'b0110111, 3'b000, 1'b0, 0, 0);
        run_instr(7'b0010111, 3'b000, 1'b0, 0, 0);
        run_random(80);

        mon_en = 1'b0;
        @(posedge clk); #1;
        chk("scoreboard_drain", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
